bus_arbiter_rr: RTL and testbench

- Round-robin arbiter sharing one req/ack/resp memory-bus slave port between two masters, e.g. the UDM debug master and the CPU data port in front of bus-unit port 1.
- Tracks outstanding reads in an in-order ID FIFO, so each response returns to the master that issued it, including when the slave pipelines reads.
- Sits between the masters and the bus unit, which it controls.

---
 rtl/bus_arbiter_rr.sv | 203 ++++++++++++++++++++
 tb/tb_bus_arbiter_rr.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter_rr.sv
// -----------------------------------------------------------------------------
// bus_arbiter_rr
//
// Round-robin arbiter that shares a single req/ack/resp memory-bus slave port
// between two masters (for example the UDM debug master and the CPU data port
// in front of bus-unit port 1). Read transfers push the issuing master id into
// an in-order ID FIFO so that every read response, including pipelined ones,
// is returned to the master that issued the read.
//
// Parameters
//   RD_DEPTH : maximum number of outstanding reads (power of two, >= 2)
//   PTR_W    : log2(RD_DEPTH)
//
// Ports
//   clk_i, rst_i              : clock (rising edge), synchronous active-high reset
//   mX_req_i / mX_we_i        : master request, 1=write 0=read
//   mX_addr_bi / mX_be_bi     : master address / byte enables
//   mX_wdata_bi               : master write data
//   mX_ack_o                  : request accepted this cycle (zero latency)
//   mX_resp_o / mX_rdata_bo   : read data valid / read data for this master
//   s_req_o .. s_wdata_bo     : request side of the shared slave port
//   s_ack_i                   : slave accepted the presented request
//   s_resp_i / s_rdata_bi     : slave read data valid / read data
//   rd_pending_bo             : registered count of outstanding reads
//   err_o                     : sticky, a response arrived with no read pending
// -----------------------------------------------------------------------------
module bus_arbiter_rr #(
    parameter int RD_DEPTH = 4,
    parameter int PTR_W    = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic             m0_req_i,
    input  logic             m0_we_i,
    input  logic [31:0]      m0_addr_bi,
    input  logic [3:0]       m0_be_bi,
    input  logic [31:0]      m0_wdata_bi,
    output logic             m0_ack_o,
    output logic             m0_resp_o,
    output logic [31:0]      m0_rdata_bo,

    input  logic             m1_req_i,
    input  logic             m1_we_i,
    input  logic [31:0]      m1_addr_bi,
    input  logic [3:0]       m1_be_bi,
    input  logic [31:0]      m1_wdata_bi,
    output logic             m1_ack_o,
    output logic             m1_resp_o,
    output logic [31:0]      m1_rdata_bo,

    output logic             s_req_o,
    output logic             s_we_o,
    output logic [31:0]      s_addr_bo,
    output logic [3:0]       s_be_bo,
    output logic [31:0]      s_wdata_bo,
    input  logic             s_ack_i,
    input  logic             s_resp_i,
    input  logic [31:0]      s_rdata_bi,

    output logic [PTR_W:0]   rd_pending_bo,
    output logic             err_o
);

    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(RD_DEPTH);

    // Control state
    logic             last_grant;
    logic [PTR_W:0]   rd_cnt;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             err_q;

    // ID storage: one bit per outstanding read (0 = m0, 1 = m1). Pure data,
    // its validity is tracked by the pointers and count, so it is not reset.
    logic [RD_DEPTH-1:0] id_mem;

    // Combinational decode
    logic fifo_full;
    logic fifo_empty;
    logic m0_elig;
    logic m1_elig;
    logic grant_vld;
    logic grant_id;
    logic xfer;
    logic push;
    logic pop;
    logic head_id;
    logic resp_spurious;

    // While reset is asserted the FIFO is treated as empty, so no response is
    // routed and reads are not blocked by stale occupancy.
    assign fifo_full  = (rd_cnt == FULL_CNT) && !rst_i;
    assign fifo_empty = (rd_cnt == '0) || rst_i;

    // A full FIFO only blocks reads; writes never need an ID slot.
    assign m0_elig = m0_req_i && (m0_we_i || !fifo_full);
    assign m1_elig = m1_req_i && (m1_we_i || !fifo_full);

    always_comb begin
        grant_vld = 1'b0;
        grant_id  = 1'b0;
        if (m0_elig && m1_elig) begin
            grant_vld = 1'b1;
            grant_id  = ~last_grant;
        end else if (m0_elig) begin
            grant_vld = 1'b1;
            grant_id  = 1'b0;
        end else if (m1_elig) begin
            grant_vld = 1'b1;
            grant_id  = 1'b1;
        end
    end

    // Slave request mux; everything is driven to zero when nobody is granted.
    always_comb begin
        s_req_o    = 1'b0;
        s_we_o     = 1'b0;
        s_addr_bo  = '0;
        s_be_bo    = '0;
        s_wdata_bo = '0;
        if (grant_vld) begin
            s_req_o = 1'b1;
            if (grant_id) begin
                s_we_o     = m1_we_i;
                s_addr_bo  = m1_addr_bi;
                s_be_bo    = m1_be_bi;
                s_wdata_bo = m1_wdata_bi;
            end else begin
                s_we_o     = m0_we_i;
                s_addr_bo  = m0_addr_bi;
                s_be_bo    = m0_be_bi;
                s_wdata_bo = m0_wdata_bi;
            end
        end
    end

    assign m0_ack_o = grant_vld && !grant_id && s_ack_i;
    assign m1_ack_o = grant_vld &&  grant_id && s_ack_i;

    assign xfer = grant_vld && s_ack_i;
    assign push = xfer && !s_we_o;

    // Response routing by the FIFO head
    assign head_id       = id_mem[rd_ptr];
    assign pop           = s_resp_i && !fifo_empty;
    assign resp_spurious = s_resp_i && fifo_empty;

    assign m0_resp_o   = pop && !head_id;
    assign m1_resp_o   = pop &&  head_id;
    assign m0_rdata_bo = (pop && !head_id) ? s_rdata_bi : '0;
    assign m1_rdata_bo = (pop &&  head_id) ? s_rdata_bi : '0;

    assign rd_pending_bo = rd_cnt;
    assign err_o         = err_q;

    // Arbitration history; reset value 1 makes m0 win the first tie.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_grant <= 1'b1;
        end else if (xfer) begin
            last_grant <= grant_id;
        end
    end

    // FIFO pointers and occupancy; push and pop are independent, a
    // simultaneous push/pop leaves the count unchanged.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            rd_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   rd_cnt <= rd_cnt + 1'b1;
                2'b01:   rd_cnt <= rd_cnt - 1'b1;
                default: rd_cnt <= rd_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            id_mem[wr_ptr] <= grant_id;
        end
    end

    // Sticky error for responses with no read outstanding
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (resp_spurious) begin
            err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bus_arbiter_rr.sv
module tb_bus_arbiter_rr;

    localparam int RD_DEPTH = 4;
    localparam int PTR_W    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        m0_req = 0, m0_we = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0;
    logic [3:0]  m0_be = 0;
    logic        m1_req = 0, m1_we = 0;
    logic [31:0] m1_addr = 0, m1_wdata = 0;
    logic [3:0]  m1_be = 0;
    logic        s_ack = 0, s_resp = 0;
    logic [31:0] s_rdata = 0;

    logic        m0_ack, m0_resp, m1_ack, m1_resp;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_req, s_we;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_be;
    logic [PTR_W:0] rd_pending;
    logic        err;

    bus_arbiter_rr #(.RD_DEPTH(RD_DEPTH), .PTR_W(PTR_W)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_bi(m0_addr), .m0_be_bi(m0_be),
        .m0_wdata_bi(m0_wdata), .m0_ack_o(m0_ack), .m0_resp_o(m0_resp), .m0_rdata_bo(m0_rdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_bi(m1_addr), .m1_be_bi(m1_be),
        .m1_wdata_bi(m1_wdata), .m1_ack_o(m1_ack), .m1_resp_o(m1_resp), .m1_rdata_bo(m1_rdata),
        .s_req_o(s_req), .s_we_o(s_we), .s_addr_bo(s_addr), .s_be_bo(s_be), .s_wdata_bo(s_wdata),
        .s_ack_i(s_ack), .s_resp_i(s_resp), .s_rdata_bi(s_rdata),
        .rd_pending_bo(rd_pending), .err_o(err)
    );

    always #5 clk = ~clk;

    int n_vec     = 0;
    int n_miscmp  = 0;

    // Reference state: scoreboard of expected response owners, last grant, error flag
    bit exp_q[$];
    bit mdl_last = 1'b1;
    bit mdl_err  = 1'b0;

    // Values observed at the last sampled negedge, for directed checks
    logic obs_m0_ack, obs_m1_ack;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: compare combinational outputs against the model at the
    // negedge, advance the model at the edge, then compare registered outputs.
    task automatic step();
        bit full, e0, e1, gv, gid, head;
        @(negedge clk);
        full = !rst && (exp_q.size() == RD_DEPTH);
        e0 = m0_req && (m0_we || !full);
        e1 = m1_req && (m1_we || !full);
        gv = e0 || e1;
        gid = (e0 && e1) ? !mdl_last : e1;
        check_eq("s_req", s_req, gv);
        check_eq("s_addr", s_addr, !gv ? 32'h0 : (gid ? m1_addr : m0_addr));
        check_eq("s_we", s_we, !gv ? 1'b0 : (gid ? m1_we : m0_we));
        check_eq("s_be", s_be, !gv ? 4'h0 : (gid ? m1_be : m0_be));
        check_eq("s_wdata", s_wdata, !gv ? 32'h0 : (gid ? m1_wdata : m0_wdata));
        check_eq("m0_ack", m0_ack, gv && !gid && s_ack);
        check_eq("m1_ack", m1_ack, gv && gid && s_ack);
        obs_m0_ack = m0_ack;
        obs_m1_ack = m1_ack;
        if (s_resp && !rst && exp_q.size() > 0) begin
            head = exp_q[0];
            check_eq("m0_resp", m0_resp, !head);
            check_eq("m1_resp", m1_resp, head);
            check_eq("m0_rdata", m0_rdata, head ? 32'h0 : s_rdata);
            check_eq("m1_rdata", m1_rdata, head ? s_rdata : 32'h0);
        end else begin
            check_eq("m0_resp_idle", m0_resp, 1'b0);
            check_eq("m1_resp_idle", m1_resp, 1'b0);
            check_eq("m0_rdata_idle", m0_rdata, 32'h0);
            check_eq("m1_rdata_idle", m1_rdata, 32'h0);
        end
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            mdl_last = 1'b1;
            mdl_err  = 1'b0;
        end else begin
            if (s_resp) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                else mdl_err = 1'b1;
            end
            if (gv && s_ack) begin
                mdl_last = gid;
                if (!(gid ? m1_we : m0_we)) exp_q.push_back(gid);
            end
        end
        #1;
        check_eq("rd_pending", rd_pending, exp_q.size());
        check_eq("err", err, mdl_err);
    endtask

    task automatic idle_inputs();
        m0_req = 0; m0_we = 0; m1_req = 0; m1_we = 0;
        s_ack = 0; s_resp = 0; s_rdata = 0;
    endtask

    initial begin
        // Reset
        idle_inputs();
        rst = 1;
        step();
        step();
        rst = 0;
        step();
        check_eq("reset_pending", rd_pending, 0);
        check_eq("reset_err", err, 0);

        // Tie-break and alternation with continuous writes
        m0_req = 1; m0_we = 1; m0_be = 4'hF; m0_wdata = 32'h0000_00A0;
        m1_req = 1; m1_we = 1; m1_be = 4'h3; m1_wdata = 32'h0000_00B1;
        s_ack = 1;
        for (int i = 0; i < 6; i++) begin
            m0_addr = 32'h1000 + i;
            m1_addr = 32'h2000 + i;
            step();
            check_eq("alt_m0_ack", obs_m0_ack, (i % 2) == 0);
            check_eq("alt_m1_ack", obs_m1_ack, (i % 2) == 1);
        end
        idle_inputs();

        // Routing: m1 reads, then m0 reads, responses in order
        m1_req = 1; m1_we = 0; m1_addr = 32'h100; s_ack = 1;
        step();
        check_eq("rt_pend1", rd_pending, 1);
        m1_req = 0;
        m0_req = 1; m0_we = 0; m0_addr = 32'h200;
        step();
        check_eq("rt_pend2", rd_pending, 2);
        idle_inputs();
        s_resp = 1; s_rdata = 32'hAAAA;
        step();
        check_eq("rt_pend3", rd_pending, 1);
        s_rdata = 32'hBBBB;
        step();
        check_eq("rt_pend4", rd_pending, 0);
        idle_inputs();

        // Full FIFO: four reads with no response
        s_ack = 1;
        for (int i = 0; i < 4; i++) begin
            m0_req = (i % 2 == 0); m1_req = (i % 2 == 1);
            m0_we = 0; m1_we = 0;
            m0_addr = 32'h300 + i; m1_addr = 32'h400 + i;
            step();
        end
        check_eq("full_pend", rd_pending, 4);
        m0_req = 1; m0_we = 0; m0_addr = 32'h500;
        m1_req = 1; m1_we = 1; m1_addr = 32'h600; m1_wdata = 32'hCAFE;
        step();
        check_eq("full_m0_blk", obs_m0_ack, 0);
        check_eq("full_m1_wr", obs_m1_ack, 1);
        m1_req = 0;
        s_resp = 1; s_rdata = 32'h1111;
        step();
        check_eq("full_still_blk", obs_m0_ack, 0);
        s_resp = 0;
        step();
        check_eq("full_unblk", obs_m0_ack, 1);
        check_eq("full_pend2", rd_pending, 4);
        idle_inputs();
        for (int i = 0; i < 4; i++) begin
            s_resp = 1; s_rdata = 32'h2220 + i;
            step();
        end
        idle_inputs();
        check_eq("drain_pend", rd_pending, 0);

        // Simultaneous push and pop
        s_ack = 1;
        m0_req = 1; m0_we = 0; m0_addr = 32'h700;
        step();
        m0_req = 0; m1_req = 1; m1_we = 0; m1_addr = 32'h704;
        step();
        check_eq("pp_pend_pre", rd_pending, 2);
        m1_req = 0; m0_req = 1; m0_addr = 32'h708;
        s_resp = 1; s_rdata = 32'h3333;
        step();
        check_eq("pp_pend", rd_pending, 2);
        idle_inputs();
        s_resp = 1; s_rdata = 32'h4444;
        step();
        s_rdata = 32'h5555;
        step();
        idle_inputs();
        check_eq("pp_drain", rd_pending, 0);

        // Spurious response
        s_resp = 1; s_rdata = 32'hDEAD;
        step();
        check_eq("spur_err", err, 1);
        idle_inputs();
        step();
        step();
        check_eq("spur_err_hold", err, 1);

        // Reset mid-operation with three reads outstanding
        s_ack = 1;
        for (int i = 0; i < 3; i++) begin
            m0_req = (i != 1); m1_req = (i == 1); m0_we = 0; m1_we = 0;
            step();
        end
        check_eq("mid_pend", rd_pending, 3);
        idle_inputs();
        rst = 1;
        s_resp = 1; s_rdata = 32'h9999;
        step();
        rst = 0;
        s_resp = 0;
        check_eq("mid_rst_pend", rd_pending, 0);
        check_eq("mid_rst_err", err, 0);
        m0_req = 1; m0_we = 1; m1_req = 1; m1_we = 1; s_ack = 1;
        step();
        check_eq("mid_tie_m0", obs_m0_ack, 1);
        idle_inputs();
        s_resp = 1;
        step();
        check_eq("late_resp_err", err, 1);
        idle_inputs();
        rst = 1;
        step();
        rst = 0;

        // Random traffic against the model
        for (int i = 0; i < 300; i++) begin
            m0_req = $urandom_range(0, 1); m0_we = $urandom_range(0, 1);
            m1_req = $urandom_range(0, 1); m1_we = $urandom_range(0, 1);
            m0_addr = $urandom; m1_addr = $urandom;
            m0_be = 4'($urandom); m1_be = 4'($urandom);
            m0_wdata = $urandom; m1_wdata = $urandom;
            s_ack = ($urandom_range(0, 3) != 0);
            s_resp = (exp_q.size() > 0) && ($urandom_range(0, 2) == 0);
            s_rdata = $urandom;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
